nv_nvdla_sdp_hls_prelu_trunc: RTL and testbench
===============================================

NV_NVDLA_SDP_HLS_PRELU_TRUNC -- requirements
Module: nv_nvdla_sdp_hls_prelu_trunc

Interface
REQ-001 Parameter IN_WIDTH, default 64, width of the incoming PReLU result.
REQ-002 Parameter OUT_WIDTH, default 32, width of the truncated, saturated output.
REQ-003 nvdla_core_clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 nvdla_core_rst  input  1  synchronous, active-high reset.
REQ-005 prelu_in_pvld  input  1  input data valid.
REQ-006 prelu_in_prdy  output  1  input ready.
REQ-007 prelu_in_data  input  IN_WIDTH  signed PReLU result (product, or zero-extended pass-through).
REQ-008 prelu_in_bypass  input  1  1 = value passed unmultiplied (positive path); the shift is skipped.
REQ-009 cfg_prelu_shift  input  6  right-shift amount, 0..63, applied to the multiplied path.
REQ-010 cfg_sat_cnt_clr  input  1  clears the saturation counter.
REQ-011 prelu_out_pvld  output  1  output valid.
REQ-012 prelu_out_prdy  input  1  output ready.
REQ-013 prelu_out_data  output  OUT_WIDTH  signed result.
REQ-014 prelu_sat_cnt  output  32  count of saturated outputs.

Function
REQ-015 A transfer occurs on a port when pvld and prdy are both 1 at a rising clock edge; data is held stable while pvld=1 and prdy=0.
REQ-016 The block is a two-stage pipeline, S1 (shift+round) and S2 (saturate); latency from input transfer to prelu_out_pvld is 2 cycles when not stalled.
REQ-017 Each stage accepts new data when its valid is 0 or the downstream stage accepts in the same cycle; prelu_in_prdy = !s1_vld | s2_accept.
REQ-018 Full throughput: one transfer per cycle is sustained when prelu_out_prdy=1 continuously.
REQ-019 cfg_prelu_shift is sampled at the S1 transfer and travels with the data; a mid-stream change affects only later inputs.
REQ-020 S1, bypass=1 or shift=0: result = prelu_in_data sign-extended to IN_WIDTH+1 bits, with no rounding.
REQ-021 S1, bypass=0 and shift=N>0: result = (data + 2^(N-1)) >>> N, computed in IN_WIDTH+1 bits (arithmetic shift, round half up), so there is no intermediate overflow.
REQ-022 S2: if the S1 result is > 2^(OUT_WIDTH-1)-1, output 0x7FFFFFFF; if it is < -2^(OUT_WIDTH-1), output 0x80000000; otherwise output the low OUT_WIDTH bits.
REQ-023 S2 sets an internal sat flag whenever clamping occurs.
REQ-024 The saturation counter increments by 1 on each output transfer whose sat flag is 1.
REQ-025 The saturation counter holds at 0xFFFFFFFF and does not wrap.
REQ-026 When cfg_sat_cnt_clr and an increment occur in the same cycle, the counter becomes 0 (clear wins).
REQ-027 A stall (prelu_out_prdy=0) holds both stages and drops or duplicates no data.

Reset
REQ-028 While nvdla_core_rst=1 at a clock edge: s1_vld=0, s2_vld=0, prelu_out_pvld=0, prelu_out_data=0, prelu_sat_cnt=0.
REQ-029 While reset is asserted, prelu_in_prdy=0.
REQ-030 Reset asserted mid-operation discards in-flight data; the first post-reset input appears 2 cycles after its transfer.
REQ-031 Datapath registers other than valids need not be reset, but the outputs above read 0 after reset.

Configuration
REQ-032 Macro NVDLA_SDP_PRELU_SAT_CNT_EN: when defined, the saturation counter and cfg_sat_cnt_clr logic are compiled in per REQ-024..026.
REQ-033 When NVDLA_SDP_PRELU_SAT_CNT_EN is undefined, prelu_sat_cnt is tied to 0, cfg_sat_cnt_clr is ignored, and the datapath is unchanged.

Verification
REQ-034 data=0x0000_0000_0000_0064, bypass=0, shift=3 -> out=0x0000000D (100/8=12.5 rounds to 13) after 2 cycles.
REQ-035 data=-100 (0xFFFF_FFFF_FFFF_FF9C), bypass=0, shift=3 -> out=0xFFFFFFF4 (-12; -12.5 rounds up); bypass=1 with the same data -> out=0xFFFFFF9C.
REQ-036 Saturation checks: data=0x0000_0001_0000_0000, shift=0 -> out=0x7FFFFFFF and sat_cnt increments to 1; data=0x8000_0000_0000_0000, shift=0 -> out=0x80000000 and sat_cnt=2.
REQ-037 Data = 0x7FFF_FFFF_FFFF_FFFF with shift=63 -> rounding add does not overflow, and out=1.
REQ-038 Back-to-back stream of 16 values with prelu_out_prdy toggled 1,0,0,1... -> all 16 outputs in order, none lost or duplicated, and prelu_in_prdy=0 only when both stages are full and stalled.
REQ-039 Reset after 2 accepted and unread inputs -> prelu_out_pvld=0 and sat_cnt=0 next cycle; with the macro undefined, sat_cnt stays 0 under REQ-036 stimulus.

Source files
------------

// File: rtl/nv_nvdla_sdp_hls_prelu_trunc.sv
// nv_nvdla_sdp_hls_prelu_trunc
// Two-stage PReLU result truncation: S1 applies a rounding arithmetic right shift,
// and S2 saturates the result to OUT_WIDTH bits with valid/ready flow control.
// Optional feature macro: NVDLA_SDP_PRELU_SAT_CNT_EN (compiles in the saturation counter).
module nv_nvdla_sdp_hls_prelu_trunc #(
   parameter int unsigned IN_WIDTH  = 64,
   parameter int unsigned OUT_WIDTH = 32
) (
   input  logic                 nvdla_core_clk,
   input  logic                 nvdla_core_rst,
   input  logic                 prelu_in_pvld,
   output logic                 prelu_in_prdy,
   input  logic [IN_WIDTH-1:0]  prelu_in_data,
   input  logic                 prelu_in_bypass,
   input  logic [5:0]           cfg_prelu_shift,
   input  logic                 cfg_sat_cnt_clr,
   output logic                 prelu_out_pvld,
   input  logic                 prelu_out_prdy,
   output logic [OUT_WIDTH-1:0] prelu_out_data,
   output logic [31:0]          prelu_sat_cnt
);

   localparam int unsigned S1_W  = IN_WIDTH + 1;
   localparam int unsigned CNT_W = 32;

   // Clamp thresholds in the S1 domain and the matching saturated output codes
   localparam logic signed [S1_W-1:0]    SAT_MAX = S1_W'({1'b0, {(OUT_WIDTH-1){1'b1}}});
   localparam logic signed [S1_W-1:0]    SAT_MIN = ~SAT_MAX;
   localparam logic [OUT_WIDTH-1:0]      OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]      OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   logic                    s1_vld_q,  s1_vld_d;
   logic signed [S1_W-1:0]  s1_data_q, s1_data_d;
   logic                    s2_vld_q,  s2_vld_d;
   logic [OUT_WIDTH-1:0]    s2_data_q, s2_data_d;
   logic                    s2_sat_q,  s2_sat_d;

   logic                    s2_accept_c;
   logic                    s1_accept_c;
   logic                    in_xfer_c;
   logic signed [S1_W-1:0]  s1_ext_c;
   logic signed [S1_W-1:0]  s1_rnd_c;
   logic signed [S1_W-1:0]  s1_sum_c;
   logic signed [S1_W-1:0]  s1_res_c;
   logic [OUT_WIDTH-1:0]    s2_res_c;
   logic                    s2_clamp_c;

   // Stage acceptance and input handshake; ready is forced low during reset
   assign s2_accept_c   = ~s2_vld_q | prelu_out_prdy;
   assign s1_accept_c   = ~s1_vld_q | s2_accept_c;
   assign prelu_in_prdy = s1_accept_c & ~nvdla_core_rst;
   assign in_xfer_c     = prelu_in_pvld & prelu_in_prdy;

   // S1 arithmetic: sign-extend one bit so the rounding add cannot overflow
   always_comb begin
      s1_ext_c = {prelu_in_data[IN_WIDTH-1], prelu_in_data};
      s1_rnd_c = S1_W'(1) << (cfg_prelu_shift - 6'd1);
      s1_sum_c = s1_ext_c + s1_rnd_c;
      if (prelu_in_bypass || (cfg_prelu_shift == 6'd0)) begin
         s1_res_c = s1_ext_c;
      end else begin
         s1_res_c = s1_sum_c >>> cfg_prelu_shift;
      end
   end

   // S2 arithmetic: clamp to the signed OUT_WIDTH range
   always_comb begin
      s2_clamp_c = 1'b0;
      s2_res_c   = s1_data_q[OUT_WIDTH-1:0];
      if (s1_data_q > SAT_MAX) begin
         s2_clamp_c = 1'b1;
         s2_res_c   = OUT_MAX;
      end else if (s1_data_q < SAT_MIN) begin
         s2_clamp_c = 1'b1;
         s2_res_c   = OUT_MIN;
      end
   end

   // Pipeline next-state: each stage loads when it can accept, otherwise holds
   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_data_d = s1_data_q;
      s2_vld_d  = s2_vld_q;
      s2_data_d = s2_data_q;
      s2_sat_d  = s2_sat_q;
      if (s1_accept_c) begin
         s1_vld_d = prelu_in_pvld;
         if (in_xfer_c) begin
            s1_data_d = s1_res_c;
         end
      end
      if (s2_accept_c) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_data_d = s2_res_c;
            s2_sat_d  = s2_clamp_c;
         end
      end
   end

   // Valids and visible output data, synchronously reset
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         s2_data_q <= '0;
         s2_sat_q  <= 1'b0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s2_vld_q  <= s2_vld_d;
         s2_data_q <= s2_data_d;
         s2_sat_q  <= s2_sat_d;
      end
   end

   // S1 data register carries no reset; it is qualified by s1_vld_q
   always_ff @(posedge nvdla_core_clk) begin
      s1_data_q <= s1_data_d;
   end

   assign prelu_out_pvld = s2_vld_q;
   assign prelu_out_data = s2_data_q;

`ifdef NVDLA_SDP_PRELU_SAT_CNT_EN
   logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
   logic             out_xfer_c;

   assign out_xfer_c = s2_vld_q & prelu_out_prdy;

   // Saturation counter: count clamped output transfers, stick at all-ones, clear wins
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (out_xfer_c && s2_sat_q && (sat_cnt_q != {CNT_W{1'b1}})) begin
         sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
      if (cfg_sat_cnt_clr) begin
         sat_cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign prelu_sat_cnt = sat_cnt_q;
`else
   logic sat_cnt_unused;

   assign sat_cnt_unused = cfg_sat_cnt_clr ^ s2_sat_q;
   assign prelu_sat_cnt  = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_prelu_trunc.sv
// Testbench for nv_nvdla_sdp_hls_prelu_trunc: directed corner cases plus a randomized
// stream, checked against an arithmetic reference model and an in-flight queue.
module tb_nv_nvdla_sdp_hls_prelu_trunc;

   typedef struct packed {
      logic [31:0] data;
      logic        sat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_pvld;
   logic        in_prdy;
   logic [63:0] in_data;
   logic        in_bypass;
   logic [5:0]  shift;
   logic        sat_clr;
   logic        out_pvld;
   logic        out_prdy;
   logic [31:0] out_data;
   logic [31:0] sat_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   exp_t        exp_q[$];
   logic [31:0] cnt_m = '0;
   logic [31:0] last_out = '0;

   nv_nvdla_sdp_hls_prelu_trunc #(.IN_WIDTH(64), .OUT_WIDTH(32)) u_dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rst  (rst),
      .prelu_in_pvld   (in_pvld),
      .prelu_in_prdy   (in_prdy),
      .prelu_in_data   (in_data),
      .prelu_in_bypass (in_bypass),
      .cfg_prelu_shift (shift),
      .cfg_sat_cnt_clr (sat_clr),
      .prelu_out_pvld  (out_pvld),
      .prelu_out_prdy  (out_prdy),
      .prelu_out_data  (out_data),
      .prelu_sat_cnt   (sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: round-half-up division by 2^N via floor division, then clamp to int32
   function automatic exp_t ref_model(input logic [63:0] d, input logic byp, input logic [5:0] sh);
      logic signed [127:0] x, q, dv;
      exp_t r;
      x = {{64{d[63]}}, d};
      if (!byp && sh != 6'd0) begin
         dv = 128'sd1 <<< sh;
         x  = x + (dv / 128'sd2);
         q  = x / dv;
         if ((x % dv) != 128'sd0 && x < 128'sd0) q = q - 128'sd1;
      end else begin
         q = x;
      end
      if (q > 128'sd2147483647) begin
         r.sat = 1'b1; r.data = 32'h7FFF_FFFF;
      end else if (q < -128'sd2147483648) begin
         r.sat = 1'b1; r.data = 32'h8000_0000;
      end else begin
         r.sat = 1'b0; r.data = q[31:0];
      end
      return r;
   endfunction

   // One clock: drive inputs, check the handshake and outputs, advance the model
   task automatic step(input logic vld, input logic [63:0] d, input logic byp, input logic [5:0] sh,
                       input logic ordy, input logic clr, output logic fired);
      exp_t        e;
      logic [31:0] nxt;
      @(negedge clk);
      in_pvld = vld; in_data = d; in_bypass = byp; shift = sh; out_prdy = ordy; sat_clr = clr;
      #1;
      check_val("in_prdy", in_prdy, !(exp_q.size() == 2 && !ordy));
      check_val("sat_cnt", sat_cnt, cnt_m);
      nxt = cnt_m;
      if (out_pvld) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_out", out_pvld, 1'b0);
         end else if (ordy) begin
            e = exp_q.pop_front();
            last_out = out_data;
            check_val("out_data", out_data, e.data);
`ifdef NVDLA_SDP_PRELU_SAT_CNT_EN
            if (e.sat && cnt_m != 32'hFFFF_FFFF) nxt = cnt_m + 32'd1;
`endif
         end
      end
`ifdef NVDLA_SDP_PRELU_SAT_CNT_EN
      if (clr) nxt = '0;
`endif
      cnt_m = nxt;
      fired = vld && in_prdy;
      if (fired) exp_q.push_back(ref_model(d, byp, sh));
   endtask

   task automatic idle(input int n);
      logic f;
      for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, f);
   endtask

   // Single transfer into an empty pipe: verify 2-cycle latency and the literal result
   task automatic directed(input string tag, input logic [63:0] d, input logic byp,
                           input logic [5:0] sh, input logic [31:0] want);
      logic f;
      step(1'b1, d, byp, sh, 1'b1, 1'b0, f);
      check_val({tag, "_acc"}, f, 1'b1);
      step(1'b0, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, f);
      check_val({tag, "_lat1"}, out_pvld, 1'b0);
      step(1'b0, 64'd0, 1'b0, 6'd0, 1'b1, 1'b0, f);
      check_val({tag, "_lat2"}, out_pvld, 1'b1);
      check_val(tag, last_out, want);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
      check_val(tag, exp_q.size(), 0);
   endtask

   function automatic logic [63:0] rand_data();
      logic [31:0] r;
      logic [63:0] v;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: v = {$urandom, $urandom};
         1: v = {{32{r[31]}}, r};
         2: v = {{24{r[31]}}, r, 8'($urandom)};
         default: begin
            case (r[1:0])
               2'd0: v = 64'h7FFF_FFFF_FFFF_FFFF;
               2'd1: v = 64'h8000_0000_0000_0000;
               2'd2: v = 64'h0000_0000_7FFF_FFFF;
               default: v = 64'hFFFF_FFFF_8000_0000;
            endcase
         end
      endcase
      return v;
   endfunction

   function automatic logic [5:0] rand_shift();
      case ($urandom_range(0, 2))
         0: return 6'd0;
         1: return 6'($urandom_range(1, 8));
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   initial begin
      logic        f, have, byp;
      logic [63:0] d;
      logic [5:0]  sh;
      int          sent;
      logic [31:0] want1, want2;

      rst = 1'b1; in_pvld = 1'b0; in_data = '0; in_bypass = 1'b0; shift = '0;
      sat_clr = 1'b0; out_prdy = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_prdy", in_prdy, 1'b0);
      check_val("rst_pvld", out_pvld, 1'b0);
      check_val("rst_data", out_data, 32'd0);
      check_val("rst_cnt", sat_cnt, 32'd0);
      rst = 1'b0;

`ifdef NVDLA_SDP_PRELU_SAT_CNT_EN
      want1 = 32'd1; want2 = 32'd2;
`else
      want1 = 32'd0; want2 = 32'd0;
`endif
      directed("pos_round", 64'h0000_0000_0000_0064, 1'b0, 6'd3, 32'h0000_000D);
      directed("neg_round", 64'hFFFF_FFFF_FFFF_FF9C, 1'b0, 6'd3, 32'hFFFF_FFF4);
      directed("neg_bypass", 64'hFFFF_FFFF_FFFF_FF9C, 1'b1, 6'd3, 32'hFFFF_FF9C);
      directed("sat_pos", 64'h0000_0001_0000_0000, 1'b0, 6'd0, 32'h7FFF_FFFF);
      idle(1);
      check_val("sat_cnt1", sat_cnt, want1);
      directed("sat_neg", 64'h8000_0000_0000_0000, 1'b0, 6'd0, 32'h8000_0000);
      idle(1);
      check_val("sat_cnt2", sat_cnt, want2);
      directed("max_sh63", 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 6'd63, 32'h0000_0001);

      // Continuous stream against a 1,0,0 ready pattern
      sent = 0;
      for (int k = 0; k < 200 && sent < 16; k++) begin
         d = 64'(sent * 37 - 200);
         step(1'b1, d, 1'b0, 6'(sent % 5), (k % 3) == 0, 1'b0, f);
         if (f) sent++;
      end
      check_val("stream_sent", sent, 16);
      drain("stream_drain");

      // Randomized traffic with holds under backpressure and occasional clears
      have = 1'b0; d = '0; byp = 1'b0; sh = '0;
      for (int k = 0; k < 1500; k++) begin
         if (!have && $urandom_range(0, 3) != 0) begin
            d = rand_data(); byp = ($urandom_range(0, 3) == 0); sh = rand_shift(); have = 1'b1;
         end
         step(have, d, byp, sh, $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0, f);
         if (f) have = 1'b0;
      end
      drain("rand_drain");

      // Reset with two accepted, unread entries in flight
      step(1'b1, 64'h0000_0001_0000_0000, 1'b0, 6'd0, 1'b0, 1'b0, f);
      check_val("mid_acc0", f, 1'b1);
      step(1'b1, 64'h0000_0000_0000_0005, 1'b0, 6'd0, 1'b0, 1'b0, f);
      check_val("mid_acc1", f, 1'b1);
      @(negedge clk);
      rst = 1'b1; in_pvld = 1'b0; out_prdy = 1'b0;
      #1;
      check_val("mid_rst_prdy", in_prdy, 1'b0);
      @(negedge clk);
      #1;
      check_val("mid_rst_pvld", out_pvld, 1'b0);
      check_val("mid_rst_data", out_data, 32'd0);
      check_val("mid_rst_cnt", sat_cnt, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      cnt_m = '0;
      directed("post_rst", 64'h0000_0000_0000_0064, 1'b0, 6'd2, 32'h0000_0019);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
